// File: rtl/svc_rv_io_arb_pkg.sv
// svc_rv_io_arb_pkg: shared constants and the rotate-and-find-first helper
// used by the svc_rv_io_arb request picker.
package svc_rv_io_arb_pkg;

  localparam int NR_MAX = 8;
  localparam int IDX_W  = $clog2(NR_MAX);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan the first nr request bits starting at start, wrapping at nr.
  function automatic pick_t rot_find_first(input logic [NR_MAX-1:0] req,
                                           input logic [IDX_W-1:0]  start,
                                           input int unsigned       nr);
    pick_t       res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 0; i < NR_MAX; i++) begin
      j = start + i;
      if (j >= nr) j = j - nr;
      if (i < nr && !res.valid && req[j[IDX_W-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = j[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/svc_rv_io_arb_pick.sv
// svc_rv_io_arb_pick: one-channel request picker. Round-robin with a grant
// pointer when SVC_RV_IO_ARB_RR_EN is defined, else fixed lowest-index priority.
module svc_rv_io_arb_pick
  import svc_rv_io_arb_pkg::*;
#(
  parameter int NR = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NR-1:0]         req,
  input  logic                  en,
  output logic                  gnt_valid,
  output logic [$clog2(NR)-1:0] gnt_idx,
  output logic [NR-1:0]         gnt
);

  localparam int IW = $clog2(NR);

  pick_t            p;
  logic [IDX_W-1:0] start;

`ifdef SVC_RV_IO_ARB_RR_EN
  logic [IW-1:0] ptr;

  assign start = IDX_W'(ptr);

  // Pointer moves just past the winner; it holds while the channel is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_valid) begin
      ptr <= (gnt_idx == IW'(NR - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst;
  assign start          = '0;
`endif

  assign p         = rot_find_first(NR_MAX'(req), start, NR);
  assign gnt_valid = en & p.valid;
  // Idle index falls back to requester 0 so downstream muxes never see X.
  assign gnt_idx   = gnt_valid ? IW'(p.idx) : '0;
  assign gnt       = gnt_valid ? (NR'(1) << gnt_idx) : '0;

endmodule

// File: rtl/svc_rv_io_arb.sv
// svc_rv_io_arb: shares one BRAM-style MMIO port between NR masters with
// independent read/write arbitration. Optional macro: SVC_RV_IO_ARB_RR_EN.
module svc_rv_io_arb
  import svc_rv_io_arb_pkg::*;
#(
  parameter int NR = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR-1:0]        m_rd_valid,
  output logic [NR-1:0]        m_rd_ready,
  input  logic [NR*AW-1:0]     m_rd_addr,
  output logic [NR-1:0]        m_rd_data_valid,
  output logic [DW-1:0]        m_rd_data,
  input  logic [NR-1:0]        m_wr_valid,
  output logic [NR-1:0]        m_wr_ready,
  input  logic [NR*AW-1:0]     m_wr_addr,
  input  logic [NR*DW-1:0]     m_wr_data,
  input  logic [NR*DW/8-1:0]   m_wr_strb,
  output logic                 io_ren,
  output logic [AW-1:0]        io_raddr,
  input  logic [DW-1:0]        io_rdata,
  output logic                 io_wen,
  output logic [AW-1:0]        io_waddr,
  output logic [DW-1:0]        io_wdata,
  output logic [DW/8-1:0]      io_wstrb
);

  localparam int IW = $clog2(NR);
  localparam int SW = DW / 8;

  logic          en;
  logic          rd_gv;
  logic          wr_gv;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic [NR-1:0] rd_gnt;
  logic [NR-1:0] wr_gnt;
  logic          rd_pend;
  logic [IW-1:0] rd_tag;

  // Grants are suppressed for the whole time reset is held.
  assign en = ~rst;

  svc_rv_io_arb_pick #(.NR(NR)) u_rd_pick (
    .clk       (clk),
    .rst       (rst),
    .req       (m_rd_valid),
    .en        (en),
    .gnt_valid (rd_gv),
    .gnt_idx   (rd_idx),
    .gnt       (rd_gnt)
  );

  svc_rv_io_arb_pick #(.NR(NR)) u_wr_pick (
    .clk       (clk),
    .rst       (rst),
    .req       (m_wr_valid),
    .en        (en),
    .gnt_valid (wr_gv),
    .gnt_idx   (wr_idx),
    .gnt       (wr_gnt)
  );

  assign m_rd_ready = rd_gnt;
  assign io_ren     = rd_gv;
  assign io_raddr   = m_rd_addr[rd_idx*AW +: AW];

  assign m_wr_ready = wr_gnt;
  assign io_wen     = wr_gv;
  assign io_waddr   = m_wr_addr[wr_idx*AW +: AW];
  assign io_wdata   = m_wr_data[wr_idx*DW +: DW];
  assign io_wstrb   = m_wr_strb[wr_idx*SW +: SW];

  // NOTE: non-blocking assignments make every register sample pre-edge values,
  // so tag and pending always describe the same accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_tag  <= '0;
    end else begin
      rd_pend <= rd_gv;
      if (rd_gv) rd_tag <= rd_idx;
    end
  end

  assign m_rd_data_valid = rd_pend ? (NR'(1) << rd_tag) : '0;
  assign m_rd_data       = io_rdata;

endmodule

// File: tb/tb_svc_rv_io_arb.sv
// tb_svc_rv_io_arb: self-checking bench for svc_rv_io_arb (NR=2) with a
// transaction-level model; follows SVC_RV_IO_ARB_RR_EN for the expected policy.
`timescale 1ns/1ps
module tb_svc_rv_io_arb;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     m_rd_valid, m_rd_ready, m_rd_data_valid;
  logic [NR-1:0]     m_wr_valid, m_wr_ready;
  logic [NR*AW-1:0]  m_rd_addr, m_wr_addr;
  logic [DW-1:0]     m_rd_data;
  logic [NR*DW-1:0]  m_wr_data;
  logic [NR*SW-1:0]  m_wr_strb;
  logic              io_ren, io_wen;
  logic [AW-1:0]     io_raddr, io_waddr;
  logic [DW-1:0]     io_rdata, io_wdata;
  logic [SW-1:0]     io_wstrb;

  always #5 clk = ~clk;

  svc_rv_io_arb #(.NR(NR), .AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .m_rd_valid      (m_rd_valid),
    .m_rd_ready      (m_rd_ready),
    .m_rd_addr       (m_rd_addr),
    .m_rd_data_valid (m_rd_data_valid),
    .m_rd_data       (m_rd_data),
    .m_wr_valid      (m_wr_valid),
    .m_wr_ready      (m_wr_ready),
    .m_wr_addr       (m_wr_addr),
    .m_wr_data       (m_wr_data),
    .m_wr_strb       (m_wr_strb),
    .io_ren          (io_ren),
    .io_raddr        (io_raddr),
    .io_rdata        (io_rdata),
    .io_wen          (io_wen),
    .io_waddr        (io_waddr),
    .io_wdata        (io_wdata),
    .io_wstrb        (io_wstrb)
  );

  // Power-on contents of every word not yet written.
  function automatic logic [DW-1:0] init_val(input logic [7:0] w);
    case (w)
      8'h04:   return 32'hDEADBEEF;
      8'h40:   return 32'h0000000A;
      8'h41:   return 32'h0000000B;
      default: return {24'h5A5A5A, w} ^ 32'h13579BDF;
    endcase
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] cur,
                                          input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r = cur;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // The io_mem stand-in: 1-cycle read latency, read-before-write on collision.
  logic [DW-1:0] mem [0:255];
  bit   [255:0]  mem_wr;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return mem_wr[a[9:2]] ? mem[a[9:2]] : init_val(a[9:2]);
  endfunction

  always @(posedge clk) begin
    if (io_ren) io_rdata <= mem_word(io_raddr);
    if (io_wen) begin
      mem[io_waddr[9:2]]    <= merge(mem_word(io_waddr), io_wdata, io_wstrb);
      mem_wr[io_waddr[9:2]] <= 1'b1;
    end
  end

  // Reference model state.
  logic [DW-1:0] exp_mem [0:255];
  bit   [255:0]  exp_wr;
  int            m_ptr_r, m_ptr_w, m_tag, last_rg, last_wg;
  bit            m_pend, rr;
  logic [DW-1:0] m_data;
  logic [NR-1:0] s_rd_ready, s_wr_ready, s_dvalid;
  logic [DW-1:0] s_rdata;
  int            checks, errors;

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    return exp_wr[a[9:2]] ? exp_mem[a[9:2]] : init_val(a[9:2]);
  endfunction

  // Winner: first asserted valid scanning upward from p, wrapping.
  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int g);
    logic [NR-1:0] r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int rg, wg, ri, wi;
    logic [AW-1:0] a;
    @(negedge clk);
    if (rst) begin
      m_pend  = 1'b0;
      m_ptr_r = 0;
      m_ptr_w = 0;
    end
    rg = rst ? -1 : pick(m_rd_valid, m_ptr_r);
    wg = rst ? -1 : pick(m_wr_valid, m_ptr_w);
    ri = (rg < 0) ? 0 : rg;
    wi = (wg < 0) ? 0 : wg;
    s_rd_ready = m_rd_ready;
    s_wr_ready = m_wr_ready;
    s_dvalid   = m_rd_data_valid;
    s_rdata    = m_rd_data;
    check("rd_ready", m_rd_ready, onehot(rg));
    check("io_ren", io_ren, rg >= 0);
    check("io_raddr", io_raddr, m_rd_addr[ri*AW +: AW]);
    check("wr_ready", m_wr_ready, onehot(wg));
    check("io_wen", io_wen, wg >= 0);
    check("io_waddr", io_waddr, m_wr_addr[wi*AW +: AW]);
    check("io_wdata", io_wdata, m_wr_data[wi*DW +: DW]);
    check("io_wstrb", io_wstrb, m_wr_strb[wi*SW +: SW]);
    check("rd_dvalid", m_rd_data_valid, m_pend ? onehot(m_tag) : '0);
    if (m_pend) check("rd_data", m_rd_data, m_data);
    @(posedge clk);
    if (!rst) begin
      m_pend = (rg >= 0);
      if (rg >= 0) begin
        m_tag  = rg;
        m_data = exp_word(m_rd_addr[rg*AW +: AW]);
      end
      if (wg >= 0) begin
        a = m_wr_addr[wg*AW +: AW];
        exp_mem[a[9:2]] = merge(exp_word(a), m_wr_data[wg*DW +: DW], m_wr_strb[wg*SW +: SW]);
        exp_wr[a[9:2]]  = 1'b1;
      end
      if (rr && rg >= 0) m_ptr_r = (rg + 1) % NR;
      if (rr && wg >= 0) m_ptr_w = (wg + 1) % NR;
    end
    last_rg = rg;
    last_wg = wg;
    #1;
  endtask

  task automatic set_rd(input int i, input logic v, input logic [AW-1:0] a);
    m_rd_valid[i]          = v;
    m_rd_addr[i*AW +: AW]  = a;
  endtask

  task automatic set_wr(input int i, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_wr_valid[i]          = v;
    m_wr_addr[i*AW +: AW]  = a;
    m_wr_data[i*DW +: DW]  = d;
    m_wr_strb[i*SW +: SW]  = s;
  endtask

  initial begin
`ifdef SVC_RV_IO_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    checks = 0; errors = 0; m_pend = 1'b0; m_tag = 0;
    m_ptr_r = 0; m_ptr_w = 0; last_rg = -1; last_wg = -1;

    // Reset held with every valid up: nothing may be granted or returned.
    rst = 1'b1;
    set_rd(0, 1'b1, 32'h100); set_rd(1, 1'b1, 32'h104);
    set_wr(0, 1'b1, 32'h200, 32'h1111_1111, 4'hF);
    set_wr(1, 1'b1, 32'h204, 32'h2222_2222, 4'hF);
    repeat (2) begin
      cycle();
      check("rst_rd_ready", s_rd_ready, '0);
      check("rst_wr_ready", s_wr_ready, '0);
      check("rst_dvalid", s_dvalid, '0);
    end

    // Release: requester 0 wins both channels straight away.
    rst = 1'b0;
    cycle();
    check("rel_rd_ready", s_rd_ready, 2'b01);
    check("rel_wr_ready", s_wr_ready, 2'b01);

    // Single read by requester 1 of 0x10.
    set_rd(0, 1'b0, 32'h100); set_rd(1, 1'b1, 32'h10);
    m_wr_valid = '0;
    cycle();
    check("single_ready", s_rd_ready, 2'b10);
    check("prev_dvalid", s_dvalid, 2'b01);
    m_rd_valid = '0;
    cycle();
    check("single_dvalid", s_dvalid, 2'b10);
    check("single_data", s_rdata, 32'hDEADBEEF);

    // Both requesters read continuously.
    set_rd(0, 1'b1, 32'h100); set_rd(1, 1'b1, 32'h104);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("rd_contend", s_rd_ready, (rr && (k % 2 == 1)) ? 2'b10 : 2'b01);
      if (k > 0) check("rd_contend_data", s_rdata, s_dvalid[1] ? 32'hB : 32'hA);
    end

    // Both requesters write continuously, then requester 0 drops out.
    m_rd_valid = '0;
    m_wr_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("wr_contend", s_wr_ready, (rr && (k % 2 == 0)) ? 2'b10 : 2'b01);
    end
    m_wr_valid = 2'b10;
    cycle();
    check("wr_handoff", s_wr_ready, 2'b10);

    // Concurrent write by 0 and read by 1.
    set_wr(0, 1'b1, 32'h20, 32'h0000_0055, 4'hF);
    m_wr_valid[1] = 1'b0;
    set_rd(0, 1'b0, 32'h0); set_rd(1, 1'b1, 32'h24);
    cycle();
    check("conc_wr_ready", s_wr_ready, 2'b01);
    check("conc_rd_ready", s_rd_ready, 2'b10);
    m_wr_valid = '0;
    set_rd(0, 1'b1, 32'h20); set_rd(1, 1'b0, 32'h24);
    cycle();
    m_rd_valid = '0;
    cycle();
    check("conc_readback", s_rdata, 32'h0000_0055);
    set_wr(0, 1'b1, 32'h20, 32'hFFFF_FFAA, 4'b0001);
    cycle();
    m_wr_valid = '0;
    m_rd_valid = 2'b01;
    cycle();
    m_rd_valid = '0;
    cycle();
    check("strb_readback", s_rdata, 32'h0000_00AA);

    // Reset right after a read grant swallows the response.
    set_rd(0, 1'b1, 32'h100);
    cycle();
    rst = 1'b1;
    m_rd_valid = '0;
    cycle();
    check("rst_drop_dvalid", s_dvalid, '0);
    rst = 1'b0;
    m_rd_valid = 2'b11;
    cycle();
    check("rst_ptr_home", s_rd_ready, 2'b01);
    m_rd_valid = '0;
    cycle();

    // Randomized traffic; a request is held stable until the model says it was taken.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (last_rg == i || !m_rd_valid[i])
          set_rd(i, $urandom_range(0, 2) != 0, AW'($urandom_range(0, 15) * 4));
        if (last_wg == i || !m_wr_valid[i])
          set_wr(i, $urandom_range(0, 2) != 0, AW'($urandom_range(0, 15) * 4),
                 $urandom, SW'($urandom_range(0, 15)));
      end
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;
    m_rd_valid = '0;
    m_wr_valid = '0;
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
